// File: rtl/bcd_multiplier_pkg.sv
// Shared types, sizes and BCD digit helpers for bcd_multiplier.
// Optional BCD_MULTIPLIER_DIGIT_CHECK_EN build uses digits_valid().
package bcd_multiplier_pkg;

  localparam int unsigned DIGITS        = 4;
  localparam int unsigned DIGIT_W       = 4;
  localparam int unsigned PROD_W        = 32;
  localparam int unsigned PROD_DIGITS   = PROD_W / DIGIT_W;
  localparam int unsigned BCD_MAX_DIGIT = 9;

  typedef enum logic [2:0] {IDLE, LOAD, ADD, SHIFT, DONE} state_t;

  function automatic logic bcd_carry(input logic [DIGIT_W:0] raw);
    return raw > (DIGIT_W+1)'(BCD_MAX_DIGIT);
  endfunction

  // Binary digit sum above 9 wraps by adding 6, the gap between hex and decimal.
  function automatic logic [DIGIT_W-1:0] bcd_fix(input logic [DIGIT_W:0] raw);
    return bcd_carry(raw) ? DIGIT_W'(raw + (DIGIT_W+1)'(6)) : raw[DIGIT_W-1:0];
  endfunction

  function automatic logic digits_valid(input logic [DIGITS*DIGIT_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++)
      if (v[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX_DIGIT)) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/bcd_multiplier_adder.sv
// 8-digit ripple decimal adder built from per-digit BCD cells; top carry dropped.
module bcd_adder_8digits
  import bcd_multiplier_pkg::*;
(
  input  logic [PROD_W-1:0] a,
  input  logic [PROD_W-1:0] b,
  output logic [PROD_W-1:0] sum
);

  logic [PROD_DIGITS-1:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < PROD_DIGITS; i++) begin : g_digit
    logic [DIGIT_W:0] raw;

    assign raw = (DIGIT_W+1)'(a[i*DIGIT_W +: DIGIT_W])
               + (DIGIT_W+1)'(b[i*DIGIT_W +: DIGIT_W])
               + (DIGIT_W+1)'(carry[i]);
    assign sum[i*DIGIT_W +: DIGIT_W] = bcd_fix(raw);

    if (i < PROD_DIGITS - 1) begin : g_carry
      assign carry[i+1] = bcd_carry(raw);
    end
  end

endmodule

// File: rtl/bcd_multiplier.sv
// Sequential 4x4-digit BCD multiplier using repeated decimal addition per digit.
// Define BCD_MULTIPLIER_DIGIT_CHECK_EN to reject non-BCD operands with err.
module bcd_multiplier
  import bcd_multiplier_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DIGITS*DIGIT_W-1:0] multiplicand,
  input  logic [DIGITS*DIGIT_W-1:0] multiplier,
  output logic [PROD_W-1:0]         product,
  output logic                      busy,
  output logic                      end_multiplication,
  output logic                      err
);

  state_t                    state;
  logic [PROD_W-1:0]         mcand;
  logic [PROD_W-1:0]         acc;
  logic [PROD_W-1:0]         acc_sum;
  logic [DIGITS*DIGIT_W-1:0] mplier;
  logic [DIGIT_W-1:0]        count;
  logic [1:0]                idx;

  bcd_adder_8digits u_adder (
    .a   (acc),
    .b   (mcand),
    .sum (acc_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      mcand              <= '0;
      acc                <= '0;
      mplier             <= '0;
      count              <= '0;
      idx                <= '0;
      product            <= '0;
      busy               <= 1'b0;
      end_multiplication <= 1'b0;
      err                <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
`ifdef BCD_MULTIPLIER_DIGIT_CHECK_EN
            if (!digits_valid(multiplicand) || !digits_valid(multiplier)) begin
              product            <= '0;
              err                <= 1'b1;
              end_multiplication <= 1'b1;
              state              <= DONE;
            end else
`endif
            begin
              mcand  <= PROD_W'(multiplicand);
              mplier <= multiplier;
              acc    <= '0;
              idx    <= '0;
              busy   <= 1'b1;
              state  <= LOAD;
            end
          end
        end
        LOAD: begin
          count <= mplier[DIGIT_W-1:0];
          state <= ADD;
        end
        ADD: begin
          if (count != '0) begin
            acc   <= acc_sum;
            count <= count - DIGIT_W'(1);
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          mcand  <= mcand << DIGIT_W;
          mplier <= mplier >> DIGIT_W;
          idx    <= idx + 2'd1;
          // Result registers load on the edge entering DONE so they are valid
          // in the same cycle end_multiplication is high.
          if (idx == 2'd3) begin
            product            <= acc;
            err                <= 1'b0;
            busy               <= 1'b0;
            end_multiplication <= 1'b1;
            state              <= DONE;
          end else begin
            state <= LOAD;
          end
        end
        DONE: begin
          end_multiplication <= 1'b0;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_multiplier.sv
// Self-checking bench for bcd_multiplier against a decimal-arithmetic model.
module tb_bcd_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic [31:0] product;
  logic        busy;
  logic        end_multiplication;
  logic        err;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned cyc    = 0;

  bit          m_active   = 1'b0;
  int unsigned m_start    = 0;
  int unsigned m_done     = 0;
  logic [31:0] m_prod     = '0;
  logic        m_err      = 1'b0;
  logic [31:0] m_held     = '0;
  logic        m_err_held = 1'b0;

  always #5 clk = ~clk;

  bcd_multiplier dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .multiplicand       (multiplicand),
    .multiplier         (multiplier),
    .product            (product),
    .busy               (busy),
    .end_multiplication (end_multiplication),
    .err                (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  function automatic longint unsigned bcd2int(input logic [31:0] v);
    longint unsigned r = 0;
    for (int i = 7; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] int2bcd(input longint unsigned n);
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad_digit(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[i*4 +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // Per-cycle comparison against the model, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (m_active && cyc == m_done) begin
      m_held     = m_prod;
      m_err_held = m_err;
    end
    check("busy", 32'(busy), 32'(m_active && cyc >= m_start && cyc < m_done));
    check("end_multiplication", 32'(end_multiplication), 32'(m_active && cyc == m_done));
    check("product", product, m_held);
    check("err", 32'(err), 32'(m_err_held));
  end

  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [31:0] lit_prod,
                     input int unsigned lit_lat, input bit lit_err, input bit retrig);
    int unsigned lat;
    int unsigned sum_digits;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    sum_digits = 0;
    for (int i = 0; i < 4; i++) sum_digits += int'(b[i*4 +: 4]);
`ifdef BCD_MULTIPLIER_DIGIT_CHECK_EN
    if (has_bad_digit(a) || has_bad_digit(b)) begin
      lat = 0; m_prod = '0; m_err = 1'b1;
    end else
`endif
    begin
      lat    = 12 + sum_digits;
      m_prod = int2bcd(bcd2int(32'(a)) * bcd2int(32'(b)));
      m_err  = 1'b0;
    end
    m_start  = cyc + 1;
    m_done   = m_start + lat;
    m_active = 1'b1;
    check("model_product", m_prod, lit_prod);
    check("model_latency", 32'(lat), 32'(lit_lat));
    @(negedge clk);
    start        = 1'b0;
    multiplicand = 16'($urandom);
    multiplier   = 16'($urandom);
    if (retrig) begin
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 200 && cyc <= m_done + 1; i++) @(negedge clk);
    if (cyc <= m_done + 1) check("run_timeout", 32'(cyc), 32'(m_done + 2));
    check("dut_product", product, lit_prod);
    check("dut_err", 32'(err), 32'(lit_err));
  endtask

  task automatic abort_run();
    @(negedge clk);
    multiplicand = 16'h1234;
    multiplier   = 16'h5678;
    start        = 1'b1;
    m_start  = cyc + 1;
    m_done   = m_start + 38;
    m_prod   = 32'h07006652;
    m_err    = 1'b0;
    m_active = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst        = 1'b1;
    m_active   = 1'b0;
    m_held     = '0;
    m_err_held = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_product", product, 32'h0);
    check("abort_end", 32'(end_multiplication), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (2) @(negedge clk);
    check("reset_product", product, 32'h0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_end", 32'(end_multiplication), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    rst = 1'b0;

    run(16'h1234, 16'h5678, 32'h07006652, 38, 1'b0, 1'b0);
    run(16'h9999, 16'h9999, 32'h99980001, 48, 1'b0, 1'b0);
    run(16'h0000, 16'h0000, 32'h00000000, 12, 1'b0, 1'b0);
    run(16'h0001, 16'h0000, 32'h00000000, 12, 1'b0, 1'b0);
    run(16'h0012, 16'h0034, 32'h00000408, 19, 1'b0, 1'b1);
    run(16'h0034, 16'h0012, 32'h00000408, 15, 1'b0, 1'b0);
    abort_run();
    run(16'h0007, 16'h0006, 32'h00000042, 18, 1'b0, 1'b0);
    run(16'h0500, 16'h0002, 32'h00001000, 14, 1'b0, 1'b0);
`ifdef BCD_MULTIPLIER_DIGIT_CHECK_EN
    run(16'h00A1, 16'h0001, 32'h00000000, 0, 1'b1, 1'b0);
    run(16'h0003, 16'h0003, 32'h00000009, 15, 1'b0, 1'b0);
`endif
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bcd_multiplier.md
BCD_MULTIPLIER -- requirements
Module: bcd_multiplier

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have ports: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: start  input  1  request, sampled in IDLE only.
REQ-004 SHALL have ports: multiplicand  input  16  4-digit packed BCD, digit 0 in [3:0].
REQ-005 SHALL have ports: multiplier  input  16  4-digit packed BCD.
REQ-006 SHALL have ports: product  output  32  8-digit packed BCD result, registered.
REQ-007 SHALL have ports: busy  output  1  high from the cycle after start is accepted until DONE.
REQ-008 SHALL have ports: end_multiplication  output  1  one-cycle pulse, product valid.
REQ-009 SHALL have ports: err  output  1  invalid-digit flag, registered, valid with end_multiplication.

Function
REQ-010 SHALL implement FSM states IDLE, LOAD, ADD, SHIFT, DONE; busy=1 in LOAD/ADD/SHIFT only; end_multiplication=1 in DONE only.
REQ-011 IDLE: on start=1, SHALL capture multiplicand zero-extended into 32-bit mcand register, multiplier into mplier register, clear 32-bit accumulator, clear 2-bit digit index, go LOAD; start=0 stays IDLE.
REQ-012 LOAD: SHALL load 4-bit count from mplier[3:0], go ADD.
REQ-013 ADD: count!=0 -> accumulator <= BCD(accumulator + mcand), count decrements, stay; count==0 -> go SHIFT with no add.
REQ-014 SHIFT: mcand shifts left one digit (4 bits), mplier shifts right one digit, index increments; index==3 before increment -> DONE, else LOAD.
REQ-015 DONE: product <= accumulator, err updated, go IDLE unconditionally.
REQ-016 Latency SHALL be exactly 12+S rising edges from the start-sampling edge to the edge entering DONE, S = sum of the four multiplier digits (max 48).
REQ-017 The adder SHALL be an 8-digit decimal adder with per-digit correction; carry-out SHALL be ignored, since 9999*9999 < 10^8 rules out overflow.
REQ-018 start SHALL be ignored while busy or in DONE; operand inputs may change freely after the capture edge.
REQ-019 product and err SHALL hold their value between DONE states.

Reset
REQ-020 rst=1 SHALL force IDLE asynchronously, clear product, accumulator, mcand, mplier, count and index to 0, and set busy, end_multiplication and err to 0.
REQ-021 rst mid-operation SHALL abort without emitting end_multiplication; the next start SHALL run normally.

Configuration
REQ-022 Macro BCD_MULTIPLIER_DIGIT_CHECK_EN defined: in IDLE, if start=1 and any operand nibble >9, SHALL skip to DONE, producing product=0 and err=1; valid operands produce err=0.
REQ-023 Macro undefined: no check; err tied 0; invalid nibbles give an unspecified product but the same FSM timing.

Structure
REQ-024 Shared package SHALL hold the FSM state enum, DIGITS=4, DIGIT_W=4, PROD_W=32 and BCD_MAX_DIGIT=9.
REQ-025 One sub-module SHALL be used: bcd_adder_8digits, built from per-digit BCD adder cells; the FSM and datapath SHALL stay in bcd_multiplier.

Verification
REQ-026 multiplicand=16'h1234, multiplier=16'h5678 -> product=32'h07006652, end_multiplication 38 edges after start, err=0.
REQ-027 16'h9999 x 16'h9999 -> product=32'h99980001 after 48 edges; no overflow corruption.
REQ-028 16'h0000 x 16'h0000 -> product=0 after 12 edges; 16'h0001 x 16'h0000 -> 0.
REQ-029 start pulsed again 5 cycles into 16'h0012 x 16'h0034 -> ignored; product=32'h00000408, single end_multiplication pulse.
REQ-030 rst asserted mid-ADD -> busy=0, product=0 immediately; a following 16'h0007 x 16'h0006 run yields 32'h00000042.
REQ-031 With BCD_MULTIPLIER_DIGIT_CHECK_EN, multiplicand=16'h00A1 -> err=1 and product=0 in DONE one edge after start.
